// File: rtl/tmds_channel_decoder.sv
// One TMDS lane receiver: word alignment by control-token search, then
// classification of each aligned word as control token, TERC4 code or video byte.
module tmds_channel_decoder #(
    parameter int LOCK_TOKENS  = 16,
    parameter int SEARCH_WORDS = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] din,
    output logic       locked,
    output logic       de,
    output logic       ctrl,
    output logic [1:0] c,
    output logic       terc4_hit,
    output logic [3:0] terc4,
    output logic [7:0] q,
    output logic [3:0] offset
);

    localparam int CNT_MAX = (SEARCH_WORDS > LOCK_TOKENS) ? SEARCH_WORDS : LOCK_TOKENS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Word pipeline and alignment window
    logic [9:0]    r0_q;
    logic [9:0]    r1_q;
    logic [9:0]    a_q;
    logic [9:0]    win;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    offset_q;
    logic [3:0]    offset_nxt;
    logic          locked_d;

    // Classification of the aligned word
    logic          tok;
    logic [1:0]    tok_c;
    logic          terc_hit;
    logic [3:0]    terc_val;
    logic [7:0]    dp;
    logic [7:0]    q_d;

    // Registered outputs
    logic          locked_q;
    logic          de_q;
    logic          ctrl_q;
    logic [1:0]    c_q;
    logic          terc4_hit_q;
    logic [3:0]    terc4_q;
    logic [7:0]    q_q;

    // r1 holds the older word, so it supplies the low (earlier) serial bits.
    assign win        = 10'({r0_q, r1_q} >> offset_q);
    assign cnt_inc    = cnt_q + 1'b1;
    assign offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        tok   = 1'b1;
        tok_c = 2'd0;
        case (a_q)
            10'b1101010100: tok_c = 2'd0;
            10'b0010101011: tok_c = 2'd1;
            10'b0101010100: tok_c = 2'd2;
            10'b1010101011: tok_c = 2'd3;
            default:        tok   = 1'b0;
        endcase
    end

    always_comb begin
        terc_hit = 1'b1;
        terc_val = 4'h0;
        case (a_q)
            10'b1010011100: terc_val = 4'h0;
            10'b1001100011: terc_val = 4'h1;
            10'b1011100100: terc_val = 4'h2;
            10'b1011100010: terc_val = 4'h3;
            10'b0101110001: terc_val = 4'h4;
            10'b0100011110: terc_val = 4'h5;
            10'b0110001110: terc_val = 4'h6;
            10'b0100111100: terc_val = 4'h7;
            10'b1011001100: terc_val = 4'h8;
            10'b0100111001: terc_val = 4'h9;
            10'b0110011100: terc_val = 4'hA;
            10'b1011000110: terc_val = 4'hB;
            10'b1010001110: terc_val = 4'hC;
            10'b1001110001: terc_val = 4'hD;
            10'b0101100011: terc_val = 4'hE;
            10'b1011000011: terc_val = 4'hF;
            default:        terc_hit = 1'b0;
        endcase
    end

    // Undo the transmitter's optional inversion, then its XOR/XNOR chain.
    always_comb begin
        dp     = a_q[9] ? ~a_q[7:0] : a_q[7:0];
        q_d    = 8'h00;
        q_d[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            q_d[i] = a_q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
        end
    end

    // Lock status after this edge; output gating follows it so the final
    // locking token already shows up as locked.
    always_comb begin
        locked_d = 1'b0;
        case (state_q)
            ST_VERIFY: locked_d = tok && (cnt_inc == CW'(LOCK_TOKENS));
            ST_LOCKED: locked_d = tok || (cnt_inc != CW'(SEARCH_WORDS));
            default:   locked_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SEARCH;
            cnt_q    <= '0;
            offset_q <= 4'd0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (tok) begin
                        state_q <= ST_VERIFY;
                        cnt_q   <= CW'(1);
                    end else if (cnt_inc == CW'(SEARCH_WORDS)) begin
                        cnt_q    <= '0;
                        offset_q <= offset_nxt;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_VERIFY: begin
                    if (!tok) begin
                        state_q <= ST_SEARCH;
                        cnt_q   <= '0;
                    end else if (cnt_inc == CW'(LOCK_TOKENS)) begin
                        state_q <= ST_LOCKED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_LOCKED: begin
                    if (tok) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == CW'(SEARCH_WORDS)) begin
                        state_q  <= ST_SEARCH;
                        cnt_q    <= '0;
                        offset_q <= offset_nxt;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_SEARCH;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r0_q        <= '0;
            r1_q        <= '0;
            a_q         <= '0;
            locked_q    <= 1'b0;
            de_q        <= 1'b0;
            ctrl_q      <= 1'b0;
            c_q         <= 2'd0;
            terc4_hit_q <= 1'b0;
            terc4_q     <= 4'd0;
            q_q         <= 8'd0;
        end else begin
            r0_q        <= din;
            r1_q        <= r0_q;
            a_q         <= win;
            locked_q    <= locked_d;
            de_q        <= locked_d & ~tok;
            ctrl_q      <= locked_d & tok;
            c_q         <= (locked_d && tok) ? tok_c : 2'd0;
            terc4_hit_q <= locked_d & ~tok & terc_hit;
            terc4_q     <= (locked_d && !tok && terc_hit) ? terc_val : 4'd0;
            q_q         <= locked_d ? q_d : 8'd0;
        end
    end

    assign locked    = locked_q;
    assign de        = de_q;
    assign ctrl      = ctrl_q;
    assign c         = c_q;
    assign terc4_hit = terc4_hit_q;
    assign terc4     = terc4_q;
    assign q         = q_q;
    assign offset    = offset_q;

endmodule
